// File: rtl/intersection_scheduler_if.sv
//------------------------------------------------------------------------------
// intersection_scheduler_if : light type package and sensor/light bus for the
// intersection scheduler. Optional emerg signal under EMERGENCY_PREEMPT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package intersection_scheduler_pkg;
  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    LEFT   = 2'd3
  } traffic_light;
endpackage

interface intersection_scheduler_if #(
  parameter int CNT_W = 8
);
  logic ns_req;
  logic ew_req;
  logic ns_left_req;
  logic ew_left_req;
`ifdef EMERGENCY_PREEMPT_EN
  logic emerg;
`endif
  intersection_scheduler_pkg::traffic_light north;
  intersection_scheduler_pkg::traffic_light south;
  intersection_scheduler_pkg::traffic_light east;
  intersection_scheduler_pkg::traffic_light west;
  logic [CNT_W-1:0] phase_timer;

`ifdef EMERGENCY_PREEMPT_EN
  modport master (
    output ns_req, ew_req, ns_left_req, ew_left_req, emerg,
    input  north, south, east, west, phase_timer
  );
  modport slave (
    input  ns_req, ew_req, ns_left_req, ew_left_req, emerg,
    output north, south, east, west, phase_timer
  );
`else
  modport master (
    output ns_req, ew_req, ns_left_req, ew_left_req,
    input  north, south, east, west, phase_timer
  );
  modport slave (
    input  ns_req, ew_req, ns_left_req, ew_left_req,
    output north, south, east, west, phase_timer
  );
`endif
endinterface

`default_nettype wire

// File: rtl/intersection_scheduler.sv
//------------------------------------------------------------------------------
// intersection_scheduler : four-way NS/EW phase scheduler with protected left,
// min/max green, yellow and all-red. Optional macro: EMERGENCY_PREEMPT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module intersection_scheduler #(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int LEFT_T    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  intersection_scheduler_if.slave   bus
);
  import intersection_scheduler_pkg::*;

  localparam logic [2:0] c_ns_left   = 3'd0;
  localparam logic [2:0] c_ns_green  = 3'd1;
  localparam logic [2:0] c_ns_yellow = 3'd2;
  localparam logic [2:0] c_ns_clear  = 3'd3;
  localparam logic [2:0] c_ew_left   = 3'd4;
  localparam logic [2:0] c_ew_green  = 3'd5;
  localparam logic [2:0] c_ew_yellow = 3'd6;
  localparam logic [2:0] c_ew_clear  = 3'd7;

  localparam logic [CNT_W-1:0] c_gmin_end   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] c_gmax_end   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] c_yellow_end = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] c_allred_end = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] c_left_end   = CNT_W'(LEFT_T - 1);
  localparam logic [CNT_W-1:0] c_timer_max  = {CNT_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ns_pend_q, ns_pend_d;
  logic             ew_pend_q, ew_pend_d;
  logic             ns_left_pend_q, ns_left_pend_d;
  logic             ew_left_pend_q, ew_left_pend_d;
  traffic_light     north_q, north_d;
  traffic_light     east_q, east_d;
  logic             emerg_w;

`ifdef EMERGENCY_PREEMPT_EN
  assign emerg_w = bus.emerg;
`else
  assign emerg_w = 1'b0;
`endif

  // Green exits need conflicting demand; continued own-direction demand holds
  // the green until the max-green point.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ns_left: begin
        if (emerg_w)                      state_d = c_ns_yellow;
        else if (timer_q >= c_left_end)   state_d = c_ns_green;
      end
      c_ns_green: begin
        if (emerg_w)
          state_d = c_ns_yellow;
        else if (timer_q >= c_gmin_end && (ew_pend_q || ew_left_pend_q) &&
                 (!bus.ns_req || timer_q >= c_gmax_end))
          state_d = c_ns_yellow;
      end
      c_ns_yellow: begin
        if (timer_q >= c_yellow_end)      state_d = c_ns_clear;
      end
      c_ns_clear: begin
        if (timer_q >= c_allred_end && !emerg_w)
          state_d = ew_left_pend_q ? c_ew_left : c_ew_green;
      end
      c_ew_left: begin
        if (emerg_w)                      state_d = c_ew_yellow;
        else if (timer_q >= c_left_end)   state_d = c_ew_green;
      end
      c_ew_green: begin
        if (emerg_w)
          state_d = c_ew_yellow;
        else if (timer_q >= c_gmin_end && (ns_pend_q || ns_left_pend_q) &&
                 (!bus.ew_req || timer_q >= c_gmax_end))
          state_d = c_ew_yellow;
      end
      c_ew_yellow: begin
        if (timer_q >= c_yellow_end)      state_d = c_ew_clear;
      end
      c_ew_clear: begin
        if (timer_q >= c_allred_end && !emerg_w)
          state_d = ns_left_pend_q ? c_ns_left : c_ns_green;
      end
      default: state_d = c_ew_clear;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = '0;
    else if (timer_q != c_timer_max)
      timer_d = timer_q + CNT_W'(1);
  end

  // A latch clears on the edge its phase is entered; that clear beats a
  // simultaneous sample because the request is being served.
  always_comb begin
    ns_left_pend_d = ns_left_pend_q | bus.ns_left_req;
    ns_pend_d      = ns_pend_q      | bus.ns_req;
    ew_left_pend_d = ew_left_pend_q | bus.ew_left_req;
    ew_pend_d      = ew_pend_q      | bus.ew_req;
    if (state_d == c_ns_left  && state_q != c_ns_left)  ns_left_pend_d = 1'b0;
    if (state_d == c_ns_green && state_q != c_ns_green) ns_pend_d      = 1'b0;
    if (state_d == c_ew_left  && state_q != c_ew_left)  ew_left_pend_d = 1'b0;
    if (state_d == c_ew_green && state_q != c_ew_green) ew_pend_d      = 1'b0;
  end

  always_comb begin
    north_d = RED;
    east_d  = RED;
    case (state_d)
      c_ns_left:   north_d = LEFT;
      c_ns_green:  north_d = GREEN;
      c_ns_yellow: north_d = YELLOW;
      c_ew_left:   east_d  = LEFT;
      c_ew_green:  east_d  = GREEN;
      c_ew_yellow: east_d  = YELLOW;
      default: begin
        north_d = RED;
        east_d  = RED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= c_ew_clear;
      timer_q        <= '0;
      ns_pend_q      <= 1'b0;
      ew_pend_q      <= 1'b0;
      ns_left_pend_q <= 1'b0;
      ew_left_pend_q <= 1'b0;
      north_q        <= RED;
      east_q         <= RED;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      ns_pend_q      <= ns_pend_d;
      ew_pend_q      <= ew_pend_d;
      ns_left_pend_q <= ns_left_pend_d;
      ew_left_pend_q <= ew_left_pend_d;
      north_q        <= north_d;
      east_q         <= east_d;
    end
  end

  // Opposing heads of an approach always show the same aspect.
  assign bus.north       = north_q;
  assign bus.south       = north_q;
  assign bus.east        = east_q;
  assign bus.west        = east_q;
  assign bus.phase_timer = timer_q;

endmodule

`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
//------------------------------------------------------------------------------
// tb_intersection_scheduler : table-driven cycle checks of lights and timer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_intersection_scheduler;
  localparam logic [1:0] G = 2'd0;
  localparam logic [1:0] Y = 2'd1;
  localparam logic [1:0] R = 2'd2;
  localparam logic [1:0] L = 2'd3;

  typedef struct {
    logic       ns_req;
    logic       ew_req;
    logic       nsl;
    logic       ewl;
    logic [1:0] exp_ns;
    logic [1:0] exp_ew;
    logic [7:0] exp_t;
  } vec_t;

  vec_t q[$];
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  intersection_scheduler_if #(.CNT_W(8)) bus ();

  intersection_scheduler #(
    .CNT_W(8), .GREEN_MIN(8), .GREEN_MAX(20),
    .YELLOW_T(3), .ALLRED_T(2), .LEFT_T(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [1:0] ens,
                       input logic [1:0] eew, input logic [7:0] et);
    total++;
    if (bus.north !== ens || bus.south !== ens || bus.east !== eew ||
        bus.west !== eew || bus.phase_timer !== et) begin
      bad++;
      $display("FAIL %s: got n=%0d s=%0d e=%0d w=%0d t=%0d, want ns=%0d ew=%0d t=%0d",
               name, bus.north, bus.south, bus.east, bus.west,
               bus.phase_timer, ens, eew, et);
    end
  endtask

  task automatic seg(input int len, input logic [1:0] ns, input logic [1:0] ew,
                     input int t0);
    for (int i = 0; i < len; i++) begin
      vec_t v;
      logic [7:0] tv;
      tv = (t0 + i > 255) ? 8'd255 : 8'(t0 + i);
      v = '{1'b0, 1'b0, 1'b0, 1'b0, ns, ew, tv};
      q.push_back(v);
    end
  endtask

  task automatic run_q(input string name);
    for (int i = 0; i < q.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), q[i].exp_ns, q[i].exp_ew, q[i].exp_t);
      bus.ns_req      = q[i].ns_req;
      bus.ew_req      = q[i].ew_req;
      bus.ns_left_req = q[i].nsl;
      bus.ew_left_req = q[i].ewl;
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  initial begin
    int b;
    bus.ns_req      = 1'b0;
    bus.ew_req      = 1'b0;
    bus.ns_left_req = 1'b0;
    bus.ew_left_req = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    bus.emerg       = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", R, R, 8'd0);

    // Idle start: 2 cycles all red, NS green rests with saturating timer,
    // then a single EW pulse after saturation forces a changeover.
    seg(2, R, R, 0);
    seg(300, G, R, 0);
    b = q.size();
    seg(2, G, R, 300);
    q[b].ew_req = 1'b1;
    seg(2, Y, R, 0);
    rst_n = 1'b1;
    run_q("idle");

    // Asynchronous reset in the middle of NS yellow.
    check("pre_reset_yellow", Y, R, 8'd2);
    #2 rst_n = 1'b0;
    #1 check("async_reset", R, R, 8'd0);
    #1 rst_n = 1'b1;

    // Min-green changeover, left-turn service, max-green forced exit.
    seg(2, R, R, 0);
    b = q.size();
    seg(8, G, R, 0);
    q[b+2].ew_req = 1'b1;
    seg(3, Y, R, 0);
    seg(2, R, R, 0);
    b = q.size();
    seg(8, R, G, 0);
    q[b+2].nsl = 1'b1;
    seg(3, R, Y, 0);
    seg(2, R, R, 0);
    seg(4, L, R, 0);
    b = q.size();
    seg(20, G, R, 0);
    for (int i = 0; i < 20; i++) q[b+i].ns_req = 1'b1;
    q[b+2].ew_req = 1'b1;
    seg(3, Y, R, 0);
    seg(2, R, R, 0);
    seg(8, R, G, 0);
    seg(3, R, Y, 0);
    seg(2, R, R, 0);
    seg(12, G, R, 0);
    run_q("seq");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
